// File: rtl/ac2_shift_acc.sv
// ---------------------------------------------------------------------------
// ac2_shift_acc - second-level bit-serial accumulator (AC2)
//
// Folds Pw weight bit-plane partial sums, arriving MSB plane first with the MSB
// plane already negated upstream, into one signed dot-product result by
// shift-and-add. It also tells the sign-correcting stage when the next plane
// is the weight MSB. The result goes out on a valid/ready handshake.
//
// Handshake rules (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A producer must not drop valid or change data until the transfer happens.
//   Input side : valid_in / in_ready, data in_ac2.
//   Output side: out_valid / out_ready, data out_ac2. out_valid and out_ac2
//                stay stable until out_ready is seen.
//
// Ports
//   clk        clock, all state changes on posedge
//   rst        synchronous reset, active-high, highest priority
//   start      begin a new product (clears the accumulator)
//   valid_in   in_ac2 holds one bit-plane partial sum
//   in_ready   plane accepted this cycle (high only while accumulating)
//   in_ac2     signed bit-plane partial sum, WI bits
//   msb_w      next plane to accept is the weight MSB plane
//   plane_cnt  remaining planes minus one (Pw-1 down to 0)
//   out_ac2    signed dot-product result, WO bits
//   out_valid  out_ac2 is valid
//   out_ready  downstream consumes out_ac2
//   busy       FSM is not idle
//   state_dbg  current FSM state (0 idle, 1 accumulate, 2 done)
// ---------------------------------------------------------------------------
module ac2_shift_acc #(
  parameter int M  = 16,
  parameter int Pa = 8,
  parameter int Pw = 8,
  localparam int WI = $clog2(M) + Pa + 1,
  localparam int WO = WI + Pw,
  localparam int CW = (Pw > 1) ? $clog2(Pw) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 valid_in,
  output logic                 in_ready,
  input  logic signed [WI-1:0] in_ac2,
  output logic                 msb_w,
  output logic [CW-1:0]        plane_cnt,
  output logic signed [WO-1:0] out_ac2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(Pw - 1);

  state_t               state;
  logic signed [WO-1:0] acc;
  logic signed [WO-1:0] in_ext;
  logic signed [WO-1:0] acc_next;

  // Sign-extend the plane sum, then double the running value and add it.
  // Earlier planes have higher weight, so each new plane shifts them up one.
  assign in_ext   = {{(WO - WI){in_ac2[WI-1]}}, in_ac2};
  assign acc_next = (acc <<< 1) + in_ext;

  // Status outputs are decoded from registered state only.
  assign in_ready  = (state == ACC);
  assign busy      = (state != IDLE);
  assign msb_w     = (state == ACC) && (plane_cnt == CNT_MAX);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      out_ac2   <= '0;
      out_valid <= 1'b0;
      plane_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= ACC;
            acc       <= '0;
            plane_cnt <= CNT_MAX;
          end
        end

        ACC: begin
          if (start) begin
            // Abort: restart the product; a plane offered now is discarded.
            acc       <= '0;
            plane_cnt <= CNT_MAX;
          end else if (valid_in) begin
            acc <= acc_next;
            if (plane_cnt == '0) begin
              // LSB plane: publish the freshly formed sum, not the old acc.
              out_ac2   <= acc_next;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              plane_cnt <= plane_cnt - 1'b1;
            end
          end
        end

        DONE: begin
          // Result is held until consumed; start alone cannot discard it.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start) begin
              state     <= ACC;
              acc       <= '0;
              plane_cnt <= CNT_MAX;
            end else begin
              state <= IDLE;
            end
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac2_shift_acc.sv
// ---------------------------------------------------------------------------
// tb_ac2_shift_acc - self-checking bench for ac2_shift_acc (Pw=4, M=16, Pa=8)
//
// Directed cases cover reset, plane ordering, held results under
// backpressure, back-to-back start and abort. The random phase builds real
// dot products from random activation/weight vectors, slices them into
// weight bit-planes, and compares each result with sum(a[i]*w[i]).
// ---------------------------------------------------------------------------
module tb_ac2_shift_acc;

  localparam int M    = 16;
  localparam int PA   = 8;
  localparam int PW   = 4;
  localparam int WI   = $clog2(M) + PA + 1;
  localparam int WO   = WI + PW;
  localparam int CW   = $clog2(PW);
  localparam int NRND = 1000;

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 valid_in;
  logic                 in_ready;
  logic signed [WI-1:0] in_ac2;
  logic                 msb_w;
  logic [CW-1:0]        plane_cnt;
  logic signed [WO-1:0] out_ac2;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic [1:0]           state_dbg;

  ac2_shift_acc #(.M(M), .Pa(PA), .Pw(PW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .in_ac2    (in_ac2),
    .msb_w     (msb_w),
    .plane_cnt (plane_cnt),
    .out_ac2   (out_ac2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [WO-1:0]     exp_q[$];
  int                n_results = 0;
  bit                drv_done  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Feed four planes back to back (MSB first) and check the result appears
  // exactly one cycle after the last accept.
  task automatic run_planes(input int p3, input int p2, input int p1, input int p0,
                            input int exp, input string tag);
    int pl[4];
    pl[0] = p3; pl[1] = p2; pl[2] = p1; pl[3] = p0;
    for (int k = 0; k < 4; k++) begin
      valid_in = 1'b1;
      in_ac2   = pl[k][WI-1:0];
      tick();
      if (k < 3) begin
        check({tag, "_no_early_valid"}, out_valid, 0);
        check({tag, "_msb_w_low"}, msb_w, 0);
      end
    end
    valid_in = 1'b0;
    check({tag, "_out_valid"}, out_valid, 1);
    check({tag, "_out_ac2"}, out_ac2, exp);
    check({tag, "_in_ready_done"}, in_ready, 0);
  endtask

  // ---------------- random phase ----------------
  task automatic rand_driver();
    int a[M];
    int w[M];
    int pl[PW];
    int expv;
    int guard;
    for (int n = 0; n < NRND; n++) begin
      expv = 0;
      for (int i = 0; i < M; i++) begin
        a[i] = int'($urandom_range(0, 255));
        w[i] = int'($urandom_range(0, 15)) - 8;
        expv += a[i] * w[i];
      end
      for (int b = 0; b < PW; b++) begin
        pl[b] = 0;
        for (int i = 0; i < M; i++) pl[b] += a[i] * ((w[i] >>> b) & 1);
      end
      pl[PW-1] = -pl[PW-1];

      // Hold start until the block enters accumulation; junk planes offered
      // meanwhile must be ignored.
      start = 1'b1;
      guard = 0;
      do begin
        valid_in = 1'($urandom_range(0, 1));
        in_ac2   = WI'($urandom_range(0, 4095));
        tick();
        guard++;
      end while (!(busy && in_ready && msb_w) && guard < 200);
      start    = 1'b0;
      valid_in = 1'b0;
      if (guard >= 200) check("rand_start_timeout", guard, 0);
      exp_q.push_back(expv[WO-1:0]);

      for (int b = PW - 1; b >= 0; b--) begin
        for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
        valid_in = 1'b1;
        in_ac2   = pl[b][WI-1:0];
        tick();
        valid_in = 1'b0;
      end
    end
    drv_done = 1;
  endtask

  task automatic rand_monitor();
    int guard = 0;
    logic [WO-1:0] e;
    while (!(drv_done && exp_q.size() == 0) && guard < 60000) begin
      @(posedge clk);
      #1;
      out_ready = 1'($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rand_unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("rand_out_ac2", out_ac2, $signed(e));
          n_results++;
        end
      end
      guard++;
    end
    if (guard >= 60000) check("rand_monitor_timeout", guard, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; valid_in = 1'b0; in_ac2 = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_msb_w", msb_w, 0);
    check("rst_plane_cnt", plane_cnt, 0);
    check("rst_out_ac2", out_ac2, 0);
    rst = 1'b0;
    tick();

    // Weight -3 times activation sum 5.
    out_ready = 1'b1;
    pulse_start();
    check("t2_busy", busy, 1);
    check("t2_in_ready", in_ready, 1);
    check("t2_msb_w_first", msb_w, 1);
    check("t2_plane_cnt", plane_cnt, PW - 1);
    run_planes(-5, 5, 0, 5, -15, "t2");
    tick();
    check("t2_idle_after", busy, 0);
    check("t2_out_valid_clr", out_valid, 0);
    check("t2_out_ac2_held", out_ac2, -15);

    // Reset mid-product clears everything, including the last result.
    pulse_start();
    valid_in = 1'b1; in_ac2 = WI'(3);
    tick();
    valid_in = 1'b0;
    check("t1_plane_cnt_mid", plane_cnt, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t1_busy", busy, 0);
    check("t1_out_valid", out_valid, 0);
    check("t1_in_ready", in_ready, 0);
    check("t1_out_ac2", out_ac2, 0);
    check("t1_plane_cnt", plane_cnt, 0);
    tick();

    // Weight -1 (all ones) and weight LSB only.
    pulse_start();
    run_planes(-7, 7, 7, 7, -7, "t3a");
    tick();
    pulse_start();
    run_planes(0, 0, 0, 7, 7, "t3b");
    tick();

    // Backpressure: result held while upstream keeps offering.
    out_ready = 1'b0;
    pulse_start();
    run_planes(1, 2, 3, 4, 26, "t4");
    for (int c = 0; c < 5; c++) begin
      valid_in = 1'b1;
      in_ac2   = WI'(99);
      start    = (c == 2);
      tick();
      check("t4_in_ready_stall", in_ready, 0);
      check("t4_out_valid_hold", out_valid, 1);
      check("t4_out_ac2_hold", out_ac2, 26);
    end
    valid_in  = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    check("t4_b2b_in_ready", in_ready, 1);
    check("t4_b2b_msb_w", msb_w, 1);
    check("t4_b2b_out_valid", out_valid, 0);
    run_planes(-1, 0, 0, 0, -8, "t4b");
    tick();

    // Abort on the third plane; the plane offered with start is dropped.
    pulse_start();
    valid_in = 1'b1; in_ac2 = WI'(3);
    tick();
    tick();
    start = 1'b1; in_ac2 = WI'(50);
    tick();
    start = 1'b0; valid_in = 1'b0;
    check("t5_plane_cnt", plane_cnt, PW - 1);
    check("t5_msb_w", msb_w, 1);
    check("t5_in_ready", in_ready, 1);
    run_planes(0, 0, 0, 2, 2, "t5");
    tick();
    tick();

    fork
      rand_driver();
      rand_monitor();
    join
    check("rand_result_count", n_results, NRND);
    check("rand_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
